// File: rtl/drive_clk_mon_pkg.sv
// Shared types and derived constants for the drive-clock monitor.
// Pure declarations; no timing or flow control.
package drive_clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACQUIRE,
      LOCKED,
      LOST
   } state_e;

   function automatic int exp_half(input int in_khz, input int exp_khz);
      return in_khz / (2 * exp_khz);
   endfunction

   function automatic int timeout_cycles(input int mult, input int half);
      return mult * half;
   endfunction

   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/drive_clk_monitor_sync_edge_det.sv
// Synchronizes mon_clk and emits a one-cycle pulse per transition, 3 cycles after the change.
// DRIVE_CLK_MON_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 cycles, rejects 1-cycle pulses).
module sync_edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic edge_o
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;
   logic edge_q;
   logic level;

   // The sync chain and the level history are deliberately not reset, so that a
   // steady-high mon_clk does not look like a fresh edge when reset is released.
   always_ff @(posedge clk_i) begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
   end

`ifdef DRIVE_CLK_MON_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   always_ff @(posedge clk_i) begin
      hist_q <= {hist_q[0], sync2_q};
      filt_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
   end

   assign level = filt_q;
`else
   assign level = sync2_q;
`endif

   always_ff @(posedge clk_i) begin
      prev_q <= level;
      if (rst_i) begin
         edge_q <= 1'b0;
      end else begin
         edge_q <= level ^ prev_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/drive_clk_monitor.sv
// Measures mon_clk half-periods against in_clk; flags lock, frequency error and loss. Strobe 4 cycles after a transition.
// DRIVE_CLK_MON_GLITCH_FILTER_EN (in sync_edge_det) adds 2 cycles of latency.
module drive_clk_monitor
   import drive_clk_mon_pkg::*;
#(
   parameter int  IN_FREQ_KHZ  = 16000,
   parameter int  EXP_FREQ_KHZ = 300,
   parameter int  TOL_CYCLES   = 2,
   parameter int  LOCK_COUNT   = 4,
   parameter int  TIMEOUT_MULT = 4,
   localparam int EXP_HALF     = exp_half(IN_FREQ_KHZ, EXP_FREQ_KHZ),
   localparam int TIMEOUT      = timeout_cycles(TIMEOUT_MULT, EXP_HALF),
   localparam int W            = cnt_width(TIMEOUT)
) (
   input  logic         in_clk,
   input  logic         reset,
   input  logic         mon_clk,
   input  logic         err_clr,
   output logic [W-1:0] half_period,
   output logic         period_valid,
   output logic         locked,
   output logic         freq_err,
   output logic         clk_lost
);

   localparam int GW = $clog2(LOCK_COUNT + 1);

   state_e        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [W-1:0]  half_q, half_d;
   logic [GW-1:0] good_q, good_d;
   logic          pv_q, pv_d;
   logic          ferr_q, ferr_d;

   logic          edge_det;
   logic          at_timeout;
   logic [W-1:0]  sample;
   int            sample_i;
   logic          in_tol;
   logic          measure;
   logic          bad_sample;

   sync_edge_det u_sync_edge_det (
      .clk_i   (in_clk),
      .rst_i   (reset),
      .async_i (mon_clk),
      .edge_o  (edge_det)
   );

   assign at_timeout = (cnt_q == W'(TIMEOUT));
   assign sample     = cnt_q + W'(1);
   assign sample_i   = int'(sample);
   assign in_tol     = (sample_i >= EXP_HALF - TOL_CYCLES) && (sample_i <= EXP_HALF + TOL_CYCLES);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      good_d     = good_q;
      half_d     = half_q;
      pv_d       = 1'b0;
      measure    = 1'b0;
      bad_sample = 1'b0;

      if (edge_det) begin
         cnt_d = '0;
      end else if (!at_timeout) begin
         cnt_d = cnt_q + W'(1);
      end

      if (edge_det) begin
         unique case (state_q)
            ACQUIRE, LOCKED: begin
               // An edge arriving on a saturated count closes an invalid gap.
               if (at_timeout) begin
                  state_d = ACQUIRE;
                  good_d  = '0;
               end else begin
                  measure = 1'b1;
               end
            end
            default: begin
               state_d = ACQUIRE;
               good_d  = '0;
            end
         endcase
      end else if (at_timeout) begin
         state_d = LOST;
         good_d  = '0;
      end

      if (measure) begin
         pv_d   = 1'b1;
         half_d = sample;
         if (!in_tol) begin
            bad_sample = 1'b1;
            state_d    = ACQUIRE;
            good_d     = '0;
         end else if (state_q == ACQUIRE) begin
            if (good_q == GW'(LOCK_COUNT - 1)) begin
               state_d = LOCKED;
               good_d  = '0;
            end else begin
               good_d = good_q + GW'(1);
            end
         end
      end

      // A new error outranks a simultaneous clear.
      ferr_d = (ferr_q & ~err_clr) | bad_sample;
   end

   always_ff @(posedge in_clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         good_q  <= '0;
         half_q  <= '0;
         pv_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         good_q  <= good_d;
         half_q  <= half_d;
         pv_q    <= pv_d;
         ferr_q  <= ferr_d;
      end
   end

   assign half_period  = half_q;
   assign period_valid = pv_q;
   assign locked       = (state_q == LOCKED);
   assign freq_err     = ferr_q;
   assign clk_lost     = (state_q == LOST);

endmodule

// File: tb/tb_drive_clk_monitor.sv
// Directed bench for drive_clk_monitor at default parameters (EXP_HALF 26, TIMEOUT 104).
module tb_drive_clk_monitor;

   logic       in_clk = 1'b0;
   logic       reset = 1'b1;
   logic       mon_clk = 1'b0;
   logic       err_clr = 1'b0;
   logic [6:0] half_period;
   logic       period_valid;
   logic       locked;
   logic       freq_err;
   logic       clk_lost;

   int         vec = 0;
   int         bad = 0;

   int         strobes;
   logic [6:0] last_hp;
   logic       last_locked;
   logic       last_ferr;

`ifdef DRIVE_CLK_MON_GLITCH_FILTER_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   drive_clk_monitor dut (
      .in_clk       (in_clk),
      .reset        (reset),
      .mon_clk      (mon_clk),
      .err_clr      (err_clr),
      .half_period  (half_period),
      .period_valid (period_valid),
      .locked       (locked),
      .freq_err     (freq_err),
      .clk_lost     (clk_lost)
   );

   always #5 in_clk = ~in_clk;

   task automatic tick();
      @(posedge in_clk);
      #1;
      if (period_valid) begin
         strobes     = strobes + 1;
         last_hp     = half_period;
         last_locked = locked;
         last_ferr   = freq_err;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clr_rec();
      strobes     = 0;
      last_hp     = '0;
      last_locked = 1'b0;
      last_ferr   = 1'b0;
   endtask

   // Toggle now, then wait n cycles; the strobe seen here measures the previous wait.
   task automatic half(input int n);
      mon_clk = ~mon_clk;
      run(n);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run(3);
      vec++; if (half_period !== 7'd0) begin bad++; $display("FAIL rst_half_period: got %0d want 0", half_period); end
      vec++; if (period_valid !== 1'b0) begin bad++; $display("FAIL rst_period_valid: got %0b want 0", period_valid); end
      vec++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %0b want 0", locked); end
      vec++; if (freq_err !== 1'b0) begin bad++; $display("FAIL rst_freq_err: got %0b want 0", freq_err); end
      vec++; if (clk_lost !== 1'b0) begin bad++; $display("FAIL rst_clk_lost: got %0b want 0", clk_lost); end
      reset = 1'b0;
   endtask

   task automatic test_steady();
      clr_rec();
      half(26);
      vec++; if (strobes !== 0) begin bad++; $display("FAIL steady_first_edge: got %0d strobes want 0", strobes); end
      for (int k = 1; k <= 4; k++) begin
         clr_rec();
         half(26);
         vec++; if (strobes !== 1) begin bad++; $display("FAIL steady_strobe%0d: got %0d strobes want 1", k, strobes); end
         vec++; if (last_hp !== 7'd26) begin bad++; $display("FAIL steady_hp%0d: got %0d want 26", k, last_hp); end
         vec++; if (last_locked !== (k == 4)) begin bad++; $display("FAIL steady_locked%0d: got %0b want %0b", k, last_locked, k == 4); end
      end
      vec++; if (freq_err !== 1'b0) begin bad++; $display("FAIL steady_freq_err: got %0b want 0", freq_err); end
   endtask

   task automatic test_out_of_tol();
      half(30);
      clr_rec();
      half(26);
      vec++; if (last_hp !== 7'd30) begin bad++; $display("FAIL oot_hp: got %0d want 30", last_hp); end
      vec++; if (last_ferr !== 1'b1) begin bad++; $display("FAIL oot_freq_err: got %0b want 1", last_ferr); end
      vec++; if (last_locked !== 1'b0) begin bad++; $display("FAIL oot_unlock: got %0b want 0", last_locked); end
      for (int k = 1; k <= 4; k++) begin
         clr_rec();
         half(26);
         vec++; if (last_locked !== (k == 4)) begin bad++; $display("FAIL oot_relock%0d: got %0b want %0b", k, last_locked, k == 4); end
      end
   endtask

   task automatic test_err_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vec++; if (freq_err !== 1'b0) begin bad++; $display("FAIL clr_alone1: got %0b want 0", freq_err); end
      half(20);
      clr_rec();
      mon_clk = ~mon_clk;
      run(LAT);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      run(26 - LAT - 1);
      vec++; if (strobes !== 1 || last_hp !== 7'd20) begin bad++; $display("FAIL clr_collide_hp: got %0d strobes hp %0d want 1 hp 20", strobes, last_hp); end
      vec++; if (last_ferr !== 1'b1) begin bad++; $display("FAIL clr_collide_set_wins: got %0b want 1", last_ferr); end
      vec++; if (freq_err !== 1'b1) begin bad++; $display("FAIL clr_collide_sticky: got %0b want 1", freq_err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      vec++; if (freq_err !== 1'b0) begin bad++; $display("FAIL clr_alone2: got %0b want 0", freq_err); end
   endtask

   task automatic test_tol_boundary();
      for (int k = 1; k <= 4; k++) half(26);
      vec++; if (locked !== 1'b1) begin bad++; $display("FAIL bnd_pre_lock: got %0b want 1", locked); end
      half(28);
      clr_rec();
      half(24);
      vec++; if (last_hp !== 7'd28 || last_locked !== 1'b1 || last_ferr !== 1'b0) begin bad++; $display("FAIL bnd_28: got hp %0d lk %0b fe %0b want 28 1 0", last_hp, last_locked, last_ferr); end
      clr_rec();
      half(29);
      vec++; if (last_hp !== 7'd24 || last_locked !== 1'b1 || last_ferr !== 1'b0) begin bad++; $display("FAIL bnd_24: got hp %0d lk %0b fe %0b want 24 1 0", last_hp, last_locked, last_ferr); end
      clr_rec();
      half(26);
      vec++; if (last_hp !== 7'd29 || last_locked !== 1'b0 || last_ferr !== 1'b1) begin bad++; $display("FAIL bnd_29: got hp %0d lk %0b fe %0b want 29 0 1", last_hp, last_locked, last_ferr); end
   endtask

   task automatic test_loss();
      int first;
      for (int k = 1; k <= 4; k++) half(26);
      vec++; if (locked !== 1'b1) begin bad++; $display("FAIL loss_pre_lock: got %0b want 1", locked); end
      first = 0;
      mon_clk = ~mon_clk;
      for (int i = 1; i <= 150; i++) begin
         tick();
         if (i == LAT + 105) begin
            vec++; if (locked !== 1'b1 || clk_lost !== 1'b0) begin bad++; $display("FAIL loss_early: got lk %0b lost %0b want 1 0", locked, clk_lost); end
         end
         if (clk_lost === 1'b1 && first == 0) begin
            first = i;
            vec++; if (locked !== 1'b0) begin bad++; $display("FAIL loss_unlock: got %0b want 0", locked); end
         end
      end
      vec++; if (first !== LAT + 106) begin bad++; $display("FAIL loss_timing: got cycle %0d want %0d", first, LAT + 106); end
      clr_rec();
      mon_clk = ~mon_clk;
      run(LAT);
      vec++; if (clk_lost !== 1'b1) begin bad++; $display("FAIL loss_hold: got %0b want 1", clk_lost); end
      tick();
      vec++; if (clk_lost !== 1'b0) begin bad++; $display("FAIL loss_clear: got %0b want 0", clk_lost); end
      run(26 - LAT - 1);
      vec++; if (strobes !== 0) begin bad++; $display("FAIL loss_gap_strobe: got %0d want 0", strobes); end
      for (int k = 1; k <= 4; k++) begin
         clr_rec();
         half(26);
         vec++; if (strobes !== 1 || last_locked !== (k == 4)) begin bad++; $display("FAIL loss_relock%0d: got %0d strobes lk %0b want 1 %0b", k, strobes, last_locked, k == 4); end
      end
   endtask

   task automatic test_reset_locked();
      vec++; if (locked !== 1'b1 || half_period !== 7'd26) begin bad++; $display("FAIL rl_pre: got lk %0b hp %0d want 1 26", locked, half_period); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vec++; if (half_period !== 7'd0 || period_valid !== 1'b0) begin bad++; $display("FAIL rl_meas: got hp %0d pv %0b want 0 0", half_period, period_valid); end
      vec++; if (locked !== 1'b0 || freq_err !== 1'b0 || clk_lost !== 1'b0) begin bad++; $display("FAIL rl_flags: got lk %0b fe %0b lost %0b want 0 0 0", locked, freq_err, clk_lost); end
      clr_rec();
      half(26);
      vec++; if (strobes !== 0) begin bad++; $display("FAIL rl_first_edge: got %0d strobes want 0", strobes); end
      clr_rec();
      half(26);
      vec++; if (strobes !== 1 || last_hp !== 7'd26) begin bad++; $display("FAIL rl_second_edge: got %0d strobes hp %0d want 1 26", strobes, last_hp); end
   endtask

   task automatic test_glitch();
      for (int k = 1; k <= 3; k++) half(26);
      vec++; if (locked !== 1'b1) begin bad++; $display("FAIL gl_pre_lock: got %0b want 1", locked); end
      clr_rec();
      mon_clk = ~mon_clk;
      run(10);
      mon_clk = ~mon_clk;
      tick();
      mon_clk = ~mon_clk;
      run(15);
`ifdef DRIVE_CLK_MON_GLITCH_FILTER_EN
      vec++; if (strobes !== 1 || last_hp !== 7'd26) begin bad++; $display("FAIL gl_window: got %0d strobes hp %0d want 1 26", strobes, last_hp); end
      clr_rec();
      half(26);
      vec++; if (last_hp !== 7'd26 || last_locked !== 1'b1 || freq_err !== 1'b0) begin bad++; $display("FAIL gl_after: got hp %0d lk %0b fe %0b want 26 1 0", last_hp, last_locked, freq_err); end
`else
      vec++; if (strobes !== 3 || last_hp !== 7'd1) begin bad++; $display("FAIL gl_window: got %0d strobes hp %0d want 3 1", strobes, last_hp); end
      vec++; if (freq_err !== 1'b1 || locked !== 1'b0) begin bad++; $display("FAIL gl_flags: got fe %0b lk %0b want 1 0", freq_err, locked); end
      clr_rec();
      half(26);
      vec++; if (strobes !== 1 || last_hp !== 7'd15) begin bad++; $display("FAIL gl_after: got %0d strobes hp %0d want 1 15", strobes, last_hp); end
`endif
   endtask

   initial begin
      clr_rec();
      test_reset();
      test_steady();
      test_out_of_tol();
      test_err_clr();
      test_tol_boundary();
      test_loss();
      test_reset_locked();
      test_glitch();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
